// File: rtl/icache_axi.sv
// Direct-mapped read-only instruction cache. It sits between the IFU's single-beat AXI4 read
// port and the system AXI4 read bus, and refills a whole line with one INCR burst on a miss.
module icache_axi #(
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  input  logic [3:0]  s_arid,
  input  logic [7:0]  s_arlen,
  input  logic [2:0]  s_arsize,
  input  logic [1:0]  s_arburst,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  output logic [3:0]  s_rid,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [3:0]  m_arid,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        fence_i,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [2:0]  state_dbg
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;

  // Handshakes: a transfer happens on a rising edge where both valid and ready are high; a
  // valid output, once raised, holds its payload stable until that edge.
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_AR, MISS_R, RESP} state_t;

  state_t             state;
  logic [31:0]        req_addr;
  logic [OFF_W-1:0]   req_off;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  logic [OFF_W-1:0]   beat_cnt;
  logic [SETS-1:0]    valid;
  logic [TAG_W-1:0]   tag_mem  [SETS];
  logic [31:0]        data_mem [SETS][LINE_WORDS];
  logic               fence_pending;
  logic               err;
  logic               hit;
  logic               bad_last;
  logic               unused_ok;

  assign req_off = req_addr[2 +: OFF_W];
  assign req_idx = req_addr[2 + OFF_W +: IDX_W];
  assign req_tag = req_addr[31 -: TAG_W];
  assign hit     = valid[req_idx] && (tag_mem[req_idx] == req_tag);

  // A refill is unusable if any beat errored, or if rlast arrived before the line was full.
  assign bad_last = err || (m_rresp != 2'b00) || (beat_cnt != OFF_W'(LINE_WORDS - 1));

  assign s_arready = (state == IDLE) && !fence_pending && !fence_i;
  assign m_arid    = 4'd0;
  assign m_arlen   = 8'(LINE_WORDS - 1);
  assign m_arsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign state_dbg = state;
  assign unused_ok = ^{s_arlen, s_arsize, s_arburst, req_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst && state == MISS_R && m_rvalid) begin
      data_mem[req_idx][beat_cnt] <= m_rdata;
      if (m_rlast) tag_mem[req_idx] <= req_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      valid         <= '0;
      fence_pending <= 1'b0;
      err           <= 1'b0;
      beat_cnt      <= '0;
      req_addr      <= '0;
      s_rid         <= '0;
      s_rdata       <= '0;
      s_rresp       <= 2'b00;
      s_rvalid      <= 1'b0;
      s_rlast       <= 1'b0;
      m_arvalid     <= 1'b0;
      m_araddr      <= '0;
      m_rready      <= 1'b0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
    end else begin
      if (fence_i && state != IDLE) fence_pending <= 1'b1;
      case (state)
        IDLE: begin
          // A fence seen in IDLE is applied at once and wins over a same-cycle request.
          if (fence_i || fence_pending) begin
            valid         <= '0;
            fence_pending <= 1'b0;
          end else if (s_arvalid) begin
            req_addr <= s_araddr;
            s_rid    <= s_arid;
            state    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            hit_cnt  <= hit_cnt + 32'd1;
            s_rdata  <= data_mem[req_idx][req_off];
            s_rvalid <= 1'b1;
            s_rlast  <= 1'b1;
            s_rresp  <= 2'b00;
            state    <= RESP;
          end else begin
            miss_cnt       <= miss_cnt + 32'd1;
            valid[req_idx] <= 1'b0;
            m_araddr       <= {req_addr[31:2+OFF_W], {(2+OFF_W){1'b0}}};
            m_arvalid      <= 1'b1;
            state          <= MISS_AR;
          end
        end
        MISS_AR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            beat_cnt  <= '0;
            state     <= MISS_R;
          end
        end
        MISS_R: begin
          if (m_rvalid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == req_off) s_rdata <= m_rdata;
            if (m_rlast) begin
              m_rready <= 1'b0;
              s_rvalid <= 1'b1;
              s_rlast  <= 1'b1;
              s_rresp  <= bad_last ? 2'b10 : 2'b00;
              err      <= bad_last;
              if (!bad_last) valid[req_idx] <= 1'b1;
              state    <= RESP;
            end else if (m_rresp != 2'b00 || beat_cnt == OFF_W'(LINE_WORDS - 1)) begin
              err <= 1'b1;
            end
          end
        end
        RESP: begin
          if (s_rready) begin
            s_rvalid <= 1'b0;
            s_rlast  <= 1'b0;
            s_rresp  <= 2'b00;
            err      <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_axi.sv
// Directed plus randomized bench for icache_axi; a set/tag/line model predicts hits, data,
// responses and counters, and the bench plays the system memory that answers refill bursts.
module tb_icache_axi;
  localparam int LW = 4;
  localparam int NS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic [3:0]  s_arid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [3:0]  s_rid;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [3:0]  m_arid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic        fence_i;
  logic [31:0] hit_cnt, miss_cnt;
  logic [2:0]  state_dbg;

  icache_axi #(.LINE_WORDS(LW), .SETS(NS)) dut (
    .clk(clk), .rst(rst),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .fence_i(fence_i), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard and reference model ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  bit          mv_valid [NS];
  logic [31:0] mv_tag   [NS];
  logic [31:0] mv_data  [NS][LW];
  logic [31:0] m_hit, m_miss;
  logic [31:0] beat_src [LW];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NS; i++) mv_valid[i] = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    s_arvalid = 0; s_araddr = '0; s_arid = '0; s_arlen = 8'd0; s_arsize = 3'b010; s_arburst = 2'b01;
    s_rready = 0; m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 0;
    fence_i = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    m_hit = 0; m_miss = 0;
  endtask

  // One IFU fetch, including the refill burst when the model predicts a miss.
  task automatic fetch(input logic [31:0] addr, input logic [3:0] id, input int ar_stall,
                       input int r_stall, input int err_beat, input int nbeats,
                       input bit fence_with_ar, input bit fence_in_refill);
    int          set, off, cnt;
    logic [31:0] tag, line_a, exp_d;
    bit          hit, bad;
    set = int'((addr / 16) % NS);
    off = int'((addr / 4) % LW);
    tag = addr / 256;
    line_a = addr - (addr % 16);
    if (fence_with_ar) model_clear();
    hit = mv_valid[set] && (mv_tag[set] == tag);
    bad = 1'b0;

    @(negedge clk);
    s_arvalid = 1; s_araddr = addr; s_arid = id; fence_i = fence_with_ar;
    #1;
    if (fence_with_ar) chk("arready_under_fence", s_arready, 0);
    cnt = 0;
    while (!s_arready && cnt < 20) begin
      @(negedge clk); fence_i = 0; #1; cnt++;
    end
    chk("ar_accept", s_arready, 1);
    @(posedge clk); #1 s_arvalid = 0; fence_i = 0;

    @(negedge clk); #1;
    chk("lookup_no_rvalid", s_rvalid, 0);
    if (hit) begin
      @(negedge clk); #1;
      chk("hit_no_refill", m_arvalid, 0);
      chk("hit_rvalid_t2", s_rvalid, 1);
      m_hit++;
      exp_q.push_back(mv_data[set][off]);
    end else begin
      m_miss++;
      cnt = 0;
      while (!m_arvalid && cnt < 20) begin
        @(negedge clk); #1; cnt++;
      end
      chk("m_arvalid", m_arvalid, 1);
      chk("m_araddr", m_araddr, line_a);
      chk("m_arlen", m_arlen, LW - 1);
      chk("m_arburst", m_arburst, 2'b01);
      chk("m_arsize", m_arsize, 3'b010);
      chk("m_arid", m_arid, 0);
      for (int i = 0; i < ar_stall; i++) begin
        @(negedge clk); #1;
        chk("m_arvalid_stall", m_arvalid, 1);
        chk("m_araddr_stall", m_araddr, line_a);
      end
      m_arready = 1;
      @(posedge clk); #1 m_arready = 0;
      bad = (nbeats < LW);
      for (int i = 0; i < nbeats; i++) begin
        repeat ($urandom_range(0, 1)) @(negedge clk);
        @(negedge clk);
        m_rvalid = 1; m_rdata = beat_src[i]; m_rresp = (i == err_beat) ? 2'b10 : 2'b00;
        m_rlast = (i == nbeats - 1);
        fence_i = (fence_in_refill && i == 0);
        if (i == err_beat) bad = 1'b1;
        #1;
        chk("m_rready", m_rready, 1);
        chk("no_extra_ar", m_arvalid, 0);
        @(posedge clk); #1 m_rvalid = 0; m_rlast = 0; m_rresp = 2'b00; fence_i = 0;
      end
      @(negedge clk); #1;
      chk("miss_rvalid_after_rlast", s_rvalid, 1);
      exp_q.push_back(beat_src[off]);
      if (bad) mv_valid[set] = 1'b0;
      else begin
        mv_valid[set] = 1'b1;
        mv_tag[set] = tag;
        for (int i = 0; i < LW; i++) mv_data[set][i] = beat_src[i];
      end
      if (fence_in_refill) model_clear();
    end

    exp_d = exp_q.pop_front();
    for (int i = 0; i < r_stall; i++) begin
      chk("rvalid_hold", s_rvalid, 1);
      if (!bad) chk("rdata_hold", s_rdata, exp_d);
      chk("rid_hold", s_rid, id);
      chk("no_ar_in_resp", m_arvalid, 0);
      @(negedge clk); #1;
    end
    s_rready = 1;
    chk("s_rvalid", s_rvalid, 1);
    chk("s_rlast", s_rlast, 1);
    chk("s_rid", s_rid, id);
    chk("s_rresp", s_rresp, bad ? 2'b10 : 2'b00);
    if (!bad) chk("s_rdata", s_rdata, exp_d);
    @(posedge clk); #1 s_rready = 0;
    @(negedge clk); #1;
    chk("rvalid_drop", s_rvalid, 0);
    chk("hit_cnt", hit_cnt, m_hit);
    chk("miss_cnt", miss_cnt, m_miss);
  endtask

  task automatic set_beats(input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input logic [31:0] b3);
    beat_src[0] = b0; beat_src[1] = b1; beat_src[2] = b2; beat_src[3] = b3;
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    logic [31:0] a;
    logic [23:0] t;
    int          cnt;
    do_reset();
    @(negedge clk); #1;
    chk("rst_arready", s_arready, 1);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_rlast", s_rlast, 0);
    chk("rst_rresp", s_rresp, 2'b00);
    chk("rst_m_arvalid", m_arvalid, 0);
    chk("rst_m_rready", m_rready, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);

    set_beats(32'h11, 32'h22, 32'h33, 32'h44);
    fetch(32'h8000_0000, 4'h3, 0, 0, -1, LW, 0, 0);
    chk("cold_miss_cnt", miss_cnt, 1);
    fetch(32'h8000_0008, 4'h5, 0, 0, -1, LW, 0, 0);
    chk("first_hit_cnt", hit_cnt, 1);

    set_beats(32'hA1, 32'hA2, 32'hA3, 32'hA4);
    fetch(32'h8000_0100, 4'h1, 0, 0, -1, LW, 0, 0);
    set_beats(32'h11, 32'h22, 32'h33, 32'h44);
    fetch(32'h8000_0000, 4'h2, 0, 0, -1, LW, 0, 0);
    chk("conflict_miss_cnt", miss_cnt, 3);

    set_beats(32'hB1, 32'hB2, 32'hB3, 32'hB4);
    fetch(32'h8000_0040, 4'h7, 0, 0, 2, LW, 0, 0);
    fetch(32'h8000_0044, 4'h8, 0, 0, -1, LW, 0, 0);
    chk("err_refetch_miss_cnt", miss_cnt, 5);

    fetch(32'h8000_0004, 4'h9, 0, 0, -1, LW, 0, 0);
    fetch(32'h8000_0004, 4'hA, 0, 0, -1, LW, 1, 0);
    chk("fence_miss_cnt", miss_cnt, 6);

    set_beats(32'hC1, 32'hC2, 32'hC3, 32'hC4);
    fetch(32'h8000_0380, 4'hB, 3, 5, -1, LW, 0, 0);
    fetch(32'h8000_008C, 4'hC, 0, 0, -1, 2, 0, 0);
    fetch(32'h8000_0084, 4'hD, 0, 0, -1, LW, 0, 0);
    fetch(32'h8000_00C0, 4'hE, 0, 0, -1, LW, 0, 1);
    fetch(32'h8000_00C0, 4'hF, 0, 0, -1, LW, 0, 0);

    // Reset in the middle of a refill: nothing partial may survive.
    @(negedge clk);
    s_arvalid = 1; s_araddr = 32'h8000_0200; s_arid = 4'h4;
    @(posedge clk); #1 s_arvalid = 0;
    cnt = 0;
    while (!m_arvalid && cnt < 20) begin
      @(negedge clk); #1; cnt++;
    end
    chk("rstmid_m_arvalid", m_arvalid, 1);
    m_arready = 1;
    @(posedge clk); #1 m_arready = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); m_rvalid = 1; m_rdata = 32'hDEAD_0000 + 32'(i);
      @(posedge clk); #1 m_rvalid = 0;
    end
    @(negedge clk); rst = 1;
    @(posedge clk); #1 rst = 0;
    model_clear();
    m_hit = 0; m_miss = 0;
    @(negedge clk); #1;
    chk("rstmid_arready", s_arready, 1);
    chk("rstmid_m_rready", m_rready, 0);
    chk("rstmid_miss_cnt", miss_cnt, 0);
    set_beats(32'hE1, 32'hE2, 32'hE3, 32'hE4);
    fetch(32'h8000_0200, 4'h4, 0, 0, -1, LW, 0, 0);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 2))
        0: t = 24'h80_0000;
        1: t = 24'h80_0001;
        default: t = 24'h12_3456;
      endcase
      a = {t, 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      for (int i = 0; i < LW; i++) beat_src[i] = $urandom;
      fetch(a, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1,
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : LW,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/icache_axi.md
Name: icache_axi

Overview:
- Direct-mapped, read-only instruction cache between the IFU's AXI4 read master and the system AXI4 read bus.
- Slave side accepts single-beat 32-bit fetches from the IFU.
- Hits are served from internal storage; misses refill a whole line with one INCR burst on the master side.
- A fence_i input invalidates all lines.

Parameters:
LINE_WORDS, 4, 32-bit words per line (power of 2, >=2)
SETS, 16, number of lines (power of 2)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
s_arvalid  input  1  IFU read request valid
s_arready  output  1  request accepted
s_araddr  input  32  fetch address (word aligned)
s_arid  input  4  request ID, echoed on s_rid
s_arlen  input  8  must be 0
s_arsize  input  3  must be 3'b010
s_arburst  input  2  ignored
s_rvalid  output  1  response valid
s_rready  input  1  IFU accepts response
s_rdata  output  32  instruction word
s_rresp  output  2  00 OKAY, 10 SLVERR
s_rlast  output  1  equals s_rvalid
s_rid  output  4  latched s_arid
m_arvalid, m_arready  output/input  1  refill request handshake
m_araddr  output  32  line-aligned refill address
m_arid  output  4  constant 0
m_arlen  output  8  LINE_WORDS-1
m_arsize  output  3  3'b010
m_arburst  output  2  2'b01 (INCR)
m_rvalid, m_rready  input/output  1  refill beat handshake
m_rdata  input  32  refill beat
m_rresp  input  2  beat response
m_rlast  input  1  last refill beat
fence_i  input  1  one-cycle pulse: invalidate all lines
hit_cnt  output  32  hits since reset, wraps
miss_cnt  output  32  misses since reset, wraps

Behaviour:
- Address split:
  - word offset = araddr[2+log2(LINE_WORDS)-1:2]
  - index = next log2(SETS) bits
  - tag = remaining upper bits
  - Defaults: offset [3:2], index [7:4], tag [31:8].
- Reset:
  - state IDLE; all valid bits 0; hit_cnt = miss_cnt = 0.
  - m_arvalid, m_rready, s_rvalid, s_rlast = 0; s_rresp = 00.
  - s_arready = 1 in the first cycle after reset.
- State IDLE:
  - s_arready = ~fence_pending & ~fence_i.
  - On s_arvalid & s_arready: latch addr/id, go to LOOKUP.
- State LOOKUP (1 cycle): compare tag and valid of the indexed line.
  - Hit: hit_cnt+1, go to RESP.
  - Miss: miss_cnt+1, go to MISS_AR with m_araddr = {tag, index, 0s}.
- State MISS_AR:
  - m_arvalid = 1, held stable until m_arready; on handshake go to MISS_R with beat_cnt = 0.
- State MISS_R:
  - m_rready = 1.
  - Each m_rvalid beat writes m_rdata into line word beat_cnt, then beat_cnt+1.
  - Any m_rresp != 00 sets sticky err.
  - On the m_rlast beat:
    - err == 0: write tag, set valid.
    - err == 1: leave the line invalid.
    - In both cases go to RESP.
  - m_rlast arriving before LINE_WORDS beats is treated the same way: the line is left invalid and err is set.
- State RESP:
  - s_rvalid = s_rlast = 1; s_rdata = latched line word at offset.
  - s_rresp = err ? 10 : 00; s_rid = latched id.
  - Held stable until s_rready. On handshake: clear err, return to IDLE.
- Latency:
  - Hit: AR handshake at cycle T, s_rvalid at T+2; back-to-back hits give one fetch per 3 cycles.
  - Miss: s_rvalid one cycle after the m_rlast beat.
- fence_i:
  - Sets fence_pending.
  - Valid bits are cleared in the first cycle the state is IDLE with fence_pending set; fence_pending is cleared in that cycle.
  - fence_i in IDLE takes priority over a simultaneous s_arvalid; that request is accepted the following cycle.
  - fence_i during a refill does not abort it: the refilled line becomes valid, then is cleared at the next IDLE.
- Counters: wrap 0xFFFFFFFF -> 0. An error refill counts as a miss only.
- rst mid-refill:
  - Returns to IDLE immediately; no partial line becomes valid.
  - The system bus shares rst, so no orphan beats are tolerated.

Test Plan:
- Reset, fetch 0x80000000 cold -> m_araddr = 0x80000000, m_arlen = 3, m_arburst = 01; beats 0x11,0x22,0x33,0x44 -> s_rdata = 0x11, s_rresp = 00, miss_cnt = 1.
- Then fetch 0x80000008 -> no m_arvalid; s_rvalid 2 cycles after the AR handshake; s_rdata = 0x33; hit_cnt = 1.
- Fetch 0x80000100 (same index 0, different tag) -> refill at 0x80000100; a subsequent fetch of 0x80000000 misses again; miss_cnt = 3.
- Refill with beat 2 rresp = 10 -> s_rresp = 10; a refetch of the same address misses.
- fence_i pulse in IDLE coincident with s_arvalid -> s_arready = 0 that cycle; the next fetch of a previously hit address misses.
- Hold s_rready = 0 for 5 cycles in RESP, and stall m_arready 3 cycles in MISS_AR -> s_rdata/s_rid and m_araddr stay stable; no extra bus request is issued.
